// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register offsets, channel indices and CTRL field positions shared by led_pwm_mmio and its bench
package led_pwm_pkg;
  localparam logic [3:0] DUTY_OFS   = 4'h0;
  localparam logic [3:0] CTRL_OFS   = 4'h4;
  localparam logic [3:0] MILLIS_OFS = 4'h8;
  localparam int NUM_CH       = 4;
  localparam int CH_BLUE      = 0;
  localparam int CH_GREEN     = 1;
  localparam int CH_RED       = 2;
  localparam int CH_LED       = 3;
  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_PRE_LSB = 8;
endpackage

// File: rtl/led_pwm_mmio_if.sv
// led_pwm_mmio_if: data-memory bus port; master drives sel/we/addr/wdata/wmask, slave returns registered rdata
interface led_pwm_mmio_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output sel, we, addr, wdata, wmask, input rdata);
  modport slave (input sel, we, addr, wdata, wmask, output rdata);
endinterface

// File: rtl/led_pwm_mmio_pwm_channel.sv
// pwm_channel: one PWM lane (clk, reset async active-low, tick, wrap, duty_in, enable -> out) with duty shadowed at period wrap
module pwm_channel (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wrap,
  input  logic [7:0] duty_in,
  input  logic       enable,
  output logic       out
);
  logic [7:0] count;
  logic [7:0] shadow;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count  <= '0;
      shadow <= '0;
      out    <= 1'b0;
    end else begin
      count  <= count + 8'(tick);
      shadow <= wrap ? duty_in : shadow;
      out    <= enable && (count < shadow);
    end
endmodule

// File: rtl/led_pwm_mmio.sv
// led_pwm_mmio: MMIO LED/RGB PWM + millisecond counter; ports clk, reset (async active-low), bus (slave), led/red/green/blue (active-high)
module led_pwm_mmio
  import led_pwm_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int MS_DIV = CLK_HZ / 1000
) (
  input  logic          clk,
  input  logic          reset,
  led_pwm_mmio_if.slave bus,
  output logic          led,
  output logic          red,
  output logic          green,
  output logic          blue
);
  localparam int DW = MS_DIV > 1 ? $clog2(MS_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MS_DIV - 1);
  logic [31:0]   duty, millis, ctrl, rmux;
  logic [3:0]    en, ch;
  logic [7:0]    prescale, pre_lim, pre_cnt, pwm_cnt;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          tick, wrap, wr, rd, div_end;
  assign idx     = bus.addr[3:2];
  assign wr      = bus.sel && bus.we;
  assign rd      = bus.sel && !bus.we;
  assign tick    = pre_cnt == pre_lim;
  assign wrap    = tick && pwm_cnt == 8'hFF;
  assign div_end = div == DIV_LAST;
  always_comb begin
    ctrl = '0;
    ctrl[CTRL_EN_LSB +: 4]  = en;
    ctrl[CTRL_PRE_LSB +: 8] = prescale;
  end
  always_comb rmux = idx == DUTY_OFS[3:2] ? duty :
                     idx == CTRL_OFS[3:2] ? ctrl :
                     idx == MILLIS_OFS[3:2] ? millis : 32'h0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      duty      <= '0;
      en        <= '0;
      prescale  <= '0;
      bus.rdata <= '0;
    end else begin
      if (wr && idx == DUTY_OFS[3:2])
        for (int i = 0; i < 4; i++)
          if (bus.wmask[i]) duty[8*i +: 8] <= bus.wdata[8*i +: 8];
      if (wr && idx == CTRL_OFS[3:2] && bus.wmask[CTRL_EN_LSB/8]) en <= bus.wdata[CTRL_EN_LSB +: 4];
      if (wr && idx == CTRL_OFS[3:2] && bus.wmask[CTRL_PRE_LSB/8]) prescale <= bus.wdata[CTRL_PRE_LSB +: 8];
      if (rd) bus.rdata <= rmux;
    end
  // the prescaler limit is latched at each prescaler wrap so a PRESCALE change never truncates a running tick interval
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pre_cnt <= '0;
      pre_lim <= '0;
      pwm_cnt <= '0;
      div     <= '0;
      millis  <= '0;
    end else begin
      pre_cnt <= tick ? 8'h0 : pre_cnt + 8'h1;
      pre_lim <= tick ? prescale : pre_lim;
      pwm_cnt <= pwm_cnt + 8'(tick);
      div     <= div_end ? '0 : div + 1'b1;
      millis  <= millis + 32'(div_end);
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .wrap   (wrap),
      .duty_in(duty[8*c +: 8]),
      .enable (en[c]),
      .out    (ch[c])
    );
  end
  assign led   = ch[CH_LED];
  assign red   = ch[CH_RED];
  assign green = ch[CH_GREEN];
  assign blue  = ch[CH_BLUE];
endmodule

// File: tb/tb_led_pwm_mmio.sv
// tb_led_pwm_mmio: self-checking bench for led_pwm_mmio (register table, PWM ratios, glitch-free update, MILLIS, reset)
module tb_led_pwm_mmio;
  import led_pwm_pkg::*;
  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic led, red, green, blue;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   pend = 1'b0;
  sb_t  sbq[$];
  sb_t  s;
  vec_t vecs[18];
  int   h_led, h_red, h_green, h_blue, hb0, hb1, hi;
  led_pwm_mmio_if bus();
  led_pwm_mmio #(.MS_DIV(10)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus),
    .led  (led),
    .red  (red),
    .green(green),
    .blue (blue)
  );
  always #5 clk = ~clk;
  // edges since reset release: with PRESCALE=0 the PWM count after edge k is k mod 256
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  always @(posedge clk) pend <= rst_n && bus.sel && !bus.we;
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endfunction
  always @(negedge clk)
    if (pend) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        s = sbq.pop_front();
        chk(s.name, bus.rdata, s.exp);
      end
    end
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    sbq.push_back(sb_t'{name: n, exp: e});
    @(posedge clk);
    #1 bus.sel = 1'b0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.wmask = m;
    @(posedge clk);
    #1 bus.sel = 1'b0; bus.we = 1'b0;
  endtask
  task automatic align(input int ph, input string n);
    for (int i = 0; i < 600 && cyc % 256 != ph; i++) @(negedge clk);
    chk(n, 32'(cyc % 256), 32'(ph));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wmask = '0;
    vecs = '{
      '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0},
      '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0},
      '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0},
      '{1'b1, 4'hC, 32'hA5A5A5A5,  4'hF, 32'h0},
      '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0},
      '{1'b1, 4'h0, 32'hFFFFFFFF,  4'h2, 32'h0},
      '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000FF00},
      '{1'b1, 4'h0, 32'h12345678,  4'h5, 32'h0},
      '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0034FF78},
      '{1'b1, 4'h4, 32'hFFFFFFF5,  4'h1, 32'h0},
      '{1'b0, 4'h4, 32'h0,         4'h0, 32'h00000005},
      '{1'b1, 4'h4, 32'h00FF0000,  4'h4, 32'h0},
      '{1'b0, 4'h4, 32'h0,         4'h0, 32'h00000005},
      '{1'b1, 4'h4, 32'h0,         4'hF, 32'h0},
      '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0},
      '{1'b1, 4'h0, 32'h0,         4'hF, 32'h0},
      '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0},
      '{1'b1, 4'h8, 32'hFFFFFFFF,  4'hF, 32'h0}
    };
    repeat (3) @(negedge clk);
    chk("outs_in_reset", 32'({led, red, green, blue}), 32'h0);
    rst_n = 1'b1;
    chk("outs_after_reset", 32'({led, red, green, blue}), 32'h0);
    foreach (vecs[i])
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      else rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    for (int i = 0; i < 1200 && cyc < 999; i++) @(negedge clk);
    chk("millis_align", 32'(cyc), 32'd999);
    rd(MILLIS_OFS, 32'd100, "millis_1000");
    @(negedge clk);
    dut.millis = 32'hFFFF_FFFF;
    repeat (9) @(negedge clk);
    rd(MILLIS_OFS, 32'd0, "millis_wrap");
    wr(CTRL_OFS, 32'h0000_000F, 4'hF);
    wr(DUTY_OFS, 32'h0040_0080, 4'hF);
    @(negedge clk);
    align(0, "duty_align");
    h_led = 0; h_red = 0; h_green = 0; h_blue = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      h_led += 32'(led); h_red += 32'(red); h_green += 32'(green); h_blue += 32'(blue);
    end
    chk("duty_led", 32'(h_led), 32'd0);
    chk("duty_red", 32'(h_red), 32'd64);
    chk("duty_green", 32'(h_green), 32'd0);
    chk("duty_blue", 32'(h_blue), 32'd128);
    hb0 = 0; hb1 = 0;
    fork
      for (int i = 0; i < 512; i++) begin
        @(negedge clk);
        if (i < 256) hb0 += 32'(blue);
        else hb1 += 32'(blue);
      end
      begin
        align(50, "glitch_align");
        wr(DUTY_OFS, 32'h0000_0010, 4'h1);
      end
    join
    chk("glitch_cur_period", 32'(hb0), 32'd128);
    chk("glitch_next_period", 32'(hb1), 32'd16);
    align(0, "en_align");
    wr(CTRL_OFS, 32'h0, 4'hF);
    chk("en_write_edge_blue", 32'(blue), 32'd1);
    @(posedge clk);
    #1;
    chk("en_off_blue", 32'(blue), 32'd0);
    chk("en_off_red", 32'(red), 32'd0);
    wr(CTRL_OFS, 32'h0000_000F, 4'hF);
    for (int i = 0; i < 600 && red !== 1'b1; i++) @(negedge clk);
    chk("rst_red_high", 32'(red), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", 32'({led, red, green, blue}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(DUTY_OFS, 32'h0, "rst_duty");
    rd(CTRL_OFS, 32'h0, "rst_ctrl");
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      hi += 32'(led | red | green | blue);
    end
    chk("rst_outs_low", 32'(hi), 32'd0);
    @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
